// File: rtl/fifo_pkg.sv
// Shared async-FIFO helpers: Gray/binary conversion and FWFT buffer depth.
// Used by both the read-side and write-side pointer stages.
package fifo_pkg;

  localparam int FWFT_DEPTH = 2;
  localparam int GRAY_MAXW  = 32;

  // Callers zero-extend narrower pointers and truncate the result back to their width.
  function automatic logic [GRAY_MAXW-1:0] bin2gray(input logic [GRAY_MAXW-1:0] b);
    return b ^ (b >> 32'd1);
  endfunction

  function automatic logic [GRAY_MAXW-1:0] gray2bin(input logic [GRAY_MAXW-1:0] g);
    logic [GRAY_MAXW-1:0] b;
    b = g;
    for (int s = 32'sd1; s < GRAY_MAXW; s = s * 32'sd2) begin
      b = b ^ (b >> s);
    end
    return b;
  endfunction

endpackage

// File: rtl/fwft_buf.sv
// Two-entry first-word-fall-through output buffer for the FIFO read side.
// Head entry is presented directly from registers; no path from pop to rdata.
module fwft_buf
  import fifo_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [DW-1:0] rdata,
  output logic          rvalid,
  output logic [1:0]    occ
);

  logic [DW-1:0] entry_r [FWFT_DEPTH];
  logic          head_r;
  logic          tail_r;
  logic [1:0]    occ_r;
  logic          pop_s;

  assign pop_s = pop & (occ_r != 2'd0);

  // Entry storage, ring indices and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      entry_r[0] <= '0;
      entry_r[1] <= '0;
      head_r     <= 1'b0;
      tail_r     <= 1'b0;
      occ_r      <= 2'd0;
    end else begin
      if (push) begin
        entry_r[tail_r] <= push_data;
        tail_r          <= ~tail_r;
      end
      if (pop_s) begin
        head_r <= ~head_r;
      end
      case ({push, pop_s})
        2'b10:   occ_r <= occ_r + 2'd1;
        2'b01:   occ_r <= occ_r - 2'd1;
        default: occ_r <= occ_r;
      endcase
    end
  end

  assign rdata  = entry_r[head_r];
  assign rvalid = (occ_r != 2'd0);
  assign occ    = occ_r;

endmodule

// File: rtl/rptr_empty_fwft.sv
// Async FIFO read-domain stage: read pointers, registered empty, RAM fetch, FWFT output.
// Define FIFO_RDCOUNT_EN to add the registered rcount occupancy output.
module rptr_empty_fwft
  import fifo_pkg::*;
#(
  parameter int AW = 4,
  parameter int DW = 8
) (
  input  logic          rclk,
  input  logic          rrst,
  input  logic [AW:0]   rq2_wptr,
  input  logic          ren,
  input  logic [DW-1:0] mem_rdata,
  output logic [AW-1:0] mem_raddr,
  output logic          mem_ren,
  output logic [AW:0]   rptr,
  output logic          rempty,
  output logic [DW-1:0] rdata,
  output logic          rvalid
`ifdef FIFO_RDCOUNT_EN
  ,
  output logic [AW+1:0] rcount
`endif
);

  localparam int PW = AW + 1;

  logic [AW:0] rbin_r;
  logic [AW:0] rptr_r;
  logic        rempty_r;
  logic        inflight_r;
  logic [AW:0] rbin_nxt_s;
  logic [AW:0] rgray_nxt_s;
  logic        pop_s;
  logic        fetch_s;
  logic [1:0]  occ_s;
  logic [2:0]  demand_s;

  // Fetch only while buffer words plus the word in flight stay within the two slots
  assign pop_s       = ren & rvalid;
  assign demand_s    = {1'b0, occ_s} - {2'b00, pop_s} + {2'b00, inflight_r};
  assign fetch_s     = ~rempty_r & (demand_s < 3'd2);
  assign rbin_nxt_s  = rbin_r + {{AW{1'b0}}, fetch_s};
  assign rgray_nxt_s = PW'(bin2gray(GRAY_MAXW'(rbin_nxt_s)));

  // Read pointers, empty flag and RAM read-latency tracker
  always_ff @(posedge rclk) begin
    if (rrst) begin
      rbin_r     <= '0;
      rptr_r     <= '0;
      rempty_r   <= 1'b1;
      inflight_r <= 1'b0;
    end else begin
      rbin_r     <= rbin_nxt_s;
      rptr_r     <= rgray_nxt_s;
      rempty_r   <= (rgray_nxt_s == rq2_wptr);
      inflight_r <= fetch_s;
    end
  end

  assign mem_ren   = fetch_s;
  assign mem_raddr = rbin_r[AW-1:0];
  assign rptr      = rptr_r;
  assign rempty    = rempty_r;

  fwft_buf #(.DW(DW)) u_buf (
    .clk       (rclk),
    .rst       (rrst),
    .push      (inflight_r),
    .push_data (mem_rdata),
    .pop       (pop_s),
    .rdata     (rdata),
    .rvalid    (rvalid),
    .occ       (occ_s)
  );

`ifdef FIFO_RDCOUNT_EN
  logic [AW:0]   wbin_s;
  logic [AW+1:0] rcount_r;

  assign wbin_s = PW'(gray2bin(GRAY_MAXW'(rq2_wptr)));

  // Conservative occupancy: lags writes by the synchronizer delay
  always_ff @(posedge rclk) begin
    if (rrst) begin
      rcount_r <= '0;
    end else begin
      rcount_r <= {1'b0, wbin_s - rbin_r} + {{AW{1'b0}}, occ_s}
                + {{(AW+1){1'b0}}, inflight_r};
    end
  end

  assign rcount = rcount_r;
`endif

endmodule

// File: tb/tb_rptr_empty_fwft.sv
// Self-checking bench for rptr_empty_fwft: RAM model, write-side driver and FIFO-order scoreboard.
module tb_rptr_empty_fwft;
  localparam int AW = 4;
  localparam int DW = 8;

  logic          rclk = 1'b0;
  logic          rrst;
  logic [AW:0]   rq2_wptr;
  logic          ren;
  logic [DW-1:0] mem_rdata = '0;
  logic [AW-1:0] mem_raddr;
  logic          mem_ren;
  logic [AW:0]   rptr;
  logic          rempty;
  logic [DW-1:0] rdata;
  logic          rvalid;
`ifdef FIFO_RDCOUNT_EN
  logic [AW+1:0] rcount;
`endif

  rptr_empty_fwft #(.AW(AW), .DW(DW)) dut (
    .rclk(rclk), .rrst(rrst), .rq2_wptr(rq2_wptr), .ren(ren),
    .mem_rdata(mem_rdata), .mem_raddr(mem_raddr), .mem_ren(mem_ren),
    .rptr(rptr), .rempty(rempty), .rdata(rdata), .rvalid(rvalid)
`ifdef FIFO_RDCOUNT_EN
    , .rcount(rcount)
`endif
  );

  always #5 rclk = ~rclk;

  // Dual-port RAM read port, one cycle of latency
  logic [DW-1:0] ram [16];
  always @(posedge rclk) if (mem_ren) mem_rdata <= ram[mem_raddr];

  int n_cmp = 0, n_fail = 0, cyc = 0, wcount = 0, pulses;
  logic [DW-1:0] exp_q[$];
  int pop_cyc_q[$];
  int addr_q[$];
  int rptr_q[$];
  logic [AW:0] prev_rptr;

  function automatic logic [4:0] gray(input int v);
    logic [4:0] b;
    b = v[4:0];
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic write_word(input logic [DW-1:0] d);
    ram[wcount % 16] = d;
    wcount++;
    rq2_wptr = gray(wcount);
    exp_q.push_back(d);
  endtask

  // Checks any pop about to happen, then advances one clock
  task automatic step();
    if (ren && rvalid) begin
      if (exp_q.size() == 0) chk("pop_underflow", 32'd1, 32'd0);
      else chk("pop_data", rdata, exp_q.pop_front());
      pop_cyc_q.push_back(cyc);
    end
    @(posedge rclk); #1;
    cyc++;
  endtask

  task automatic do_reset();
    rrst = 1'b1; ren = 1'b0; wcount = 0; rq2_wptr = '0;
    exp_q.delete();
    step(); step();
    rrst = 1'b0;
  endtask

  task automatic drain(input int budget);
    ren = 1'b1;
    for (int i = 0; i < budget && exp_q.size() != 0; i++) step();
    chk("drain_done", exp_q.size(), 32'd0);
    ren = 1'b0;
  endtask

  initial begin
    rrst = 1'b1; ren = 1'b0; rq2_wptr = '0;
    for (int i = 0; i < 16; i++) ram[i] = '0;

    // Reset state and idle with ren high
    do_reset();
    chk("rst_rempty", rempty, 1); chk("rst_rvalid", rvalid, 0);
    chk("rst_mem_ren", mem_ren, 0); chk("rst_rptr", rptr, 0); chk("rst_rdata", rdata, 0);
    ren = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("idle_rempty", rempty, 1); chk("idle_rvalid", rvalid, 0);
      chk("idle_mem_ren", mem_ren, 0); chk("idle_rptr", rptr, 0);
    end
    ren = 1'b0;

    // Single word: empty drop, fetch, RAM latency, arrival, pop
    write_word(8'hA5);
    step();
    chk("one_rempty0", rempty, 0); chk("one_mem_ren", mem_ren, 1); chk("one_raddr", mem_raddr, 0);
    step();
    chk("one_rempty1", rempty, 1); chk("one_rptr", rptr, 5'b00001);
    chk("one_no_refetch", mem_ren, 0); chk("one_rvalid_wait", rvalid, 0);
    step();
    chk("one_rvalid", rvalid, 1); chk("one_rdata", rdata, 8'hA5);
    ren = 1'b1; step();
    chk("one_popped", rvalid, 0);
    ren = 1'b0;

    // Stream 16 words back to back
    do_reset();
    for (int i = 0; i < 16; i++) write_word(DW'(i));
    pop_cyc_q.delete();
    ren = 1'b1;
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) step();
    chk("stream_drained", exp_q.size(), 0);
    chk("stream_count", pop_cyc_q.size(), 16);
    for (int i = 1; i < pop_cyc_q.size(); i++)
      chk("stream_gap", pop_cyc_q[i] - pop_cyc_q[i-1], 1);
    step();
    chk("stream_rptr", rptr, 5'b11000); chk("stream_rempty", rempty, 1); chk("stream_rvalid", rvalid, 0);
    ren = 1'b0;

    // Backpressure: only two words may leave the RAM
    do_reset();
    for (int i = 0; i < 8; i++) write_word(8'h40 + DW'(i));
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (mem_ren) pulses++;
    end
    chk("bp_pulses", pulses, 2); chk("bp_rempty", rempty, 0);
    chk("bp_rvalid", rvalid, 1); chk("bp_head", rdata, 8'h40);
    drain(40);
    ren = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("bp_no_extra", rvalid, 0);
    end
    ren = 1'b0;

    // Wrap-around: advance read pointer to 30, then read across the wrap
    do_reset();
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 15; i++) write_word(DW'($urandom));
      drain(60);
    end
    chk("wrap_pre_rptr", rptr, gray(30));
    addr_q.delete(); rptr_q.delete();
    prev_rptr = rptr;
    for (int i = 0; i < 4; i++) write_word(8'hC0 + DW'(i));
    ren = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      if (mem_ren) addr_q.push_back(int'(mem_raddr));
      if (rptr != prev_rptr) begin
        rptr_q.push_back(int'(rptr));
        prev_rptr = rptr;
      end
    end
    ren = 1'b0;
    chk("wrap_naddr", addr_q.size(), 4);
    chk("wrap_nrptr", rptr_q.size(), 4);
    if (addr_q.size() == 4) begin
      chk("wrap_addr0", addr_q[0], 14); chk("wrap_addr1", addr_q[1], 15);
      chk("wrap_addr2", addr_q[2], 0);  chk("wrap_addr3", addr_q[3], 1);
    end
    if (rptr_q.size() == 4) begin
      chk("wrap_rptr0", rptr_q[0], gray(31)); chk("wrap_rptr1", rptr_q[1], gray(0));
      chk("wrap_rptr2", rptr_q[2], gray(1));  chk("wrap_rptr3", rptr_q[3], gray(2));
    end
    chk("wrap_rempty", rempty, 1); chk("wrap_drained", exp_q.size(), 0);

    // Reset in the middle of a stream discards buffered and in-flight words
    do_reset();
    for (int i = 0; i < 8; i++) write_word(8'h80 + DW'(i));
    ren = 1'b1;
    for (int i = 0; i < 4; i++) step();
    ren = 1'b0;
    rrst = 1'b1; wcount = 0; rq2_wptr = '0;
    exp_q.delete();
    step();
    rrst = 1'b0;
    chk("mid_rvalid", rvalid, 0); chk("mid_rempty", rempty, 1);
    chk("mid_rptr", rptr, 0); chk("mid_mem_ren", mem_ren, 0);
    ren = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("mid_no_stale", rvalid, 0);
    end
    ren = 1'b0;
    write_word(8'h11); write_word(8'h22); write_word(8'h33);
    drain(20);

    // Randomized traffic against the FIFO-order scoreboard
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 1) == 1 && exp_q.size() < 16) write_word(DW'($urandom));
      ren = ($urandom_range(0, 3) != 0);
      step();
    end
    drain(80);
    step(); step();
    chk("rand_rptr", rptr, gray(wcount)); chk("rand_rempty", rempty, 1); chk("rand_rvalid", rvalid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
